// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM command/address/data bus between init, refresh, write and read.
// Define SDRAM_ARB_RR_EN for round-robin write/read arbitration (default: write beats read).
module sdram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DQ_W   = 16
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    output logic              ref_en,
    input  logic              flag_ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);
    localparam logic [4:0] S_INIT  = 5'b00001;
    localparam logic [4:0] S_ARBIT = 5'b00010;
    localparam logic [4:0] S_AREF  = 5'b00100;
    localparam logic [4:0] S_WRITE = 5'b01000;
    localparam logic [4:0] S_READ  = 5'b10000;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    logic [4:0]        state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bank_q, bank_d;
    logic [DQ_W-1:0]   dq_q, dq_d;
    logic              oe_q, oe_d;
    logic              wr_win;

`ifdef SDRAM_ARB_RR_EN
    logic last_rd_q, last_rd_d;
    // On a tie the requester not served last time wins; reset favours write.
    assign wr_win = wr_req && (!rd_req || last_rd_q);
    assign last_rd_d = (state_q == S_ARBIT && !ref_req && (wr_req || rd_req)) ? !wr_win : last_rd_q;
    always_ff @(posedge sclk or negedge s_rst_n)
        if (!s_rst_n) last_rd_q <= 1'b1;
        else last_rd_q <= last_rd_d;
`else
    assign wr_win = wr_req;
`endif

    always_comb begin
        state_d = S_ARBIT;
        case (state_q)
            S_INIT:  state_d = flag_init_end ? S_ARBIT : S_INIT;
            S_ARBIT: state_d = ref_req ? S_AREF : wr_win ? S_WRITE : rd_req ? S_READ : S_ARBIT;
            S_AREF:  state_d = flag_ref_end ? S_ARBIT : S_AREF;
            S_WRITE: state_d = flag_wr_end ? S_ARBIT : S_WRITE;
            S_READ:  state_d = flag_rd_end ? S_ARBIT : S_READ;
            default: state_d = S_ARBIT;
        endcase
    end

    assign cmd_d  = state_q == S_INIT  ? init_cmd  :
                    state_q == S_AREF  ? ref_cmd   :
                    state_q == S_WRITE ? wr_cmd    :
                    state_q == S_READ  ? rd_cmd    : CMD_NOP;
    assign addr_d = state_q == S_INIT  ? init_addr :
                    state_q == S_AREF  ? ref_addr  :
                    state_q == S_WRITE ? wr_addr   :
                    state_q == S_READ  ? rd_addr   : '0;
    assign bank_d = state_q == S_WRITE ? wr_bank   :
                    state_q == S_READ  ? rd_bank   : 2'd0;
    assign oe_d   = state_q == S_WRITE;
    assign dq_d   = oe_d ? wr_data : '0;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= S_INIT;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            bank_q  <= 2'd0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
        end
    end

    assign ref_en = state_q == S_AREF;
    assign wr_en  = state_q == S_WRITE;
    assign rd_en  = state_q == S_READ;
    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_bank   = bank_q;
    assign sdram_addr   = addr_q;
    assign sdram_dq_out = dq_q;
    assign sdram_dq_oe  = oe_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed table, grant-order sequences and a random run against an owner-level model.
module tb_sdram_arbiter;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic sclk = 1'b0, s_rst_n = 1'b0, flag_init_end = 1'b0;
    logic [3:0] init_cmd = 4'h2, ref_cmd = 4'h1, wr_cmd = 4'h4, rd_cmd = 4'h5;
    logic [11:0] init_addr = 12'h400, ref_addr = 12'h0, wr_addr = 12'd5, rd_addr = 12'd9;
    logic [1:0] wr_bank = 2'd1, rd_bank = 2'd2;
    logic [15:0] wr_data = 16'd7;
    logic ref_req = 0, wr_req = 0, rd_req = 0, flag_ref_end = 0, flag_wr_end = 0, flag_rd_end = 0;
    logic ref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dq_oe;
    logic [1:0] sdram_bank;
    logic [11:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    sdram_arbiter dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sclk = ~sclk;

    int vectors = 0, miscompares = 0;

    // Owner codes: 0 init, 1 idle/arbitration, 2 refresh, 3 write, 4 read.
    int own = 0;
    bit last_rd = 1'b1;
    logic [38:0] m_exp = 39'h0;

    function automatic logic [38:0] mk(logic [2:0] en, logic [3:0] cmd, logic [1:0] bank,
                                       logic [11:0] addr, logic [15:0] dq, logic oe);
        return {en, 1'b1, cmd, bank, addr, dq, oe};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {ref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe};
    endfunction

    task automatic chk(string name, logic [38:0] act, logic [38:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_tick();
        logic [3:0] c;
        logic [11:0] a;
        logic [1:0] b;
        int nxt;
        if (!s_rst_n) begin
            own = 0;
            last_rd = 1'b1;
            m_exp = mk(3'b000, 4'b0111, 2'd0, 12'd0, 16'd0, 1'b0);
            return;
        end
        c = own == 0 ? init_cmd : own == 2 ? ref_cmd : own == 3 ? wr_cmd : own == 4 ? rd_cmd : 4'b0111;
        a = own == 0 ? init_addr : own == 2 ? ref_addr : own == 3 ? wr_addr : own == 4 ? rd_addr : 12'd0;
        b = own == 3 ? wr_bank : own == 4 ? rd_bank : 2'd0;
        nxt = own;
        case (own)
            0: if (flag_init_end) nxt = 1;
            1: begin
                if (ref_req) nxt = 2;
                else if (wr_req && rd_req) nxt = (RR && !last_rd) ? 4 : 3;
                else if (wr_req) nxt = 3;
                else if (rd_req) nxt = 4;
                if (nxt == 3 || nxt == 4) last_rd = (nxt == 4);
            end
            2: if (flag_ref_end) nxt = 1;
            3: if (flag_wr_end) nxt = 1;
            default: if (flag_rd_end) nxt = 1;
        endcase
        m_exp = mk({nxt == 2, nxt == 3, nxt == 4}, c, b, a, own == 3 ? wr_data : 16'd0, own == 3);
        own = nxt;
    endtask

    task automatic step(bit do_chk);
        @(posedge sclk);
        #1;
        model_tick();
        if (do_chk) chk("model", dut_vec(), m_exp);
    endtask

    typedef struct {
        logic rst_n, fie;
        logic [2:0] req, fin, en;
        int sel;
    } vec_t;

    function automatic vec_t v(logic rst_n, logic fie, logic [2:0] req, logic [2:0] fin,
                               logic [2:0] en, int sel);
        vec_t r;
        r.rst_n = rst_n; r.fie = fie; r.req = req; r.fin = fin; r.en = en; r.sel = sel;
        return r;
    endfunction

    function automatic logic [38:0] pins(logic [2:0] en, int sel);
        case (sel)
            1: return mk(en, 4'b0010, 2'd0, 12'h400, 16'd0, 1'b0);
            2: return mk(en, 4'b0001, 2'd0, 12'h000, 16'd0, 1'b0);
            3: return mk(en, 4'b0100, 2'd1, 12'd5, 16'd7, 1'b1);
            4: return mk(en, 4'b0101, 2'd2, 12'd9, 16'd0, 1'b0);
            default: return mk(en, 4'b0111, 2'd0, 12'd0, 16'd0, 1'b0);
        endcase
    endfunction

    vec_t tbl[18];

    initial begin
        int g;
        logic [38:0] seen;
        tbl[0]  = v(0, 0, 3'b000, 3'b000, 3'b000, 0);
        tbl[1]  = v(1, 0, 3'b000, 3'b000, 3'b000, 1);
        tbl[2]  = v(1, 0, 3'b100, 3'b000, 3'b000, 1);
        tbl[3]  = v(1, 1, 3'b000, 3'b000, 3'b000, 1);
        tbl[4]  = v(1, 1, 3'b000, 3'b000, 3'b000, 0);
        tbl[5]  = v(1, 1, 3'b111, 3'b000, 3'b100, 0);
        tbl[6]  = v(1, 1, 3'b111, 3'b000, 3'b100, 2);
        tbl[7]  = v(1, 1, 3'b011, 3'b100, 3'b000, 2);
        tbl[8]  = v(1, 1, 3'b011, 3'b000, 3'b010, 0);
        tbl[9]  = v(1, 1, 3'b011, 3'b000, 3'b010, 3);
        tbl[10] = v(1, 1, 3'b011, 3'b001, 3'b010, 3);
        tbl[11] = v(1, 1, 3'b110, 3'b010, 3'b000, 3);
        tbl[12] = v(1, 1, 3'b110, 3'b000, 3'b100, 0);
        tbl[13] = v(1, 1, 3'b010, 3'b100, 3'b000, 2);
        tbl[14] = v(1, 1, 3'b010, 3'b000, 3'b010, 0);
        tbl[15] = v(1, 1, 3'b011, 3'b000, 3'b010, 3);
        tbl[16] = v(1, 1, 3'b011, 3'b010, 3'b000, 3);
        tbl[17] = v(1, 1, 3'b011, 3'b000, RR ? 3'b001 : 3'b010, 0);
        #1;
        for (int i = 0; i < 18; i++) begin
            s_rst_n = tbl[i].rst_n;
            flag_init_end = tbl[i].fie;
            {ref_req, wr_req, rd_req} = tbl[i].req;
            {flag_ref_end, flag_wr_end, flag_rd_end} = tbl[i].fin;
            step(1'b0);
            chk($sformatf("table[%0d]", i), dut_vec(), pins(tbl[i].en, tbl[i].sel));
        end

        // Both requesters held: grant order across successive releases.
        {ref_req, wr_req, rd_req, flag_ref_end, flag_wr_end, flag_rd_end} = '0;
        s_rst_n = 1'b0;
        step(1'b1);
        s_rst_n = 1'b1;
        flag_init_end = 1'b1;
        step(1'b1);
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (g = 0; g < 5; g++) begin
            for (int c = 0; c < 10 && !(wr_en || rd_en); c++) step(1'b1);
            seen = {37'd0, rd_en, wr_en};
            chk($sformatf("grant_order[%0d]", g), seen, (RR && g % 2 == 1) ? 39'd2 : 39'd1);
            if (g == 4) break;
            flag_wr_end = wr_en;
            flag_rd_end = rd_en;
            step(1'b1);
            flag_wr_end = 1'b0;
            flag_rd_end = 1'b0;
        end
        // Reset while the write owns the bus and its data is on the pins.
        step(1'b1);
        s_rst_n = 1'b0;
        #1;
        chk("rst_mid_write", dut_vec(), mk(3'b000, 4'b0111, 2'd0, 12'd0, 16'd0, 1'b0));
        step(1'b1);

        for (int n = 0; n < 1500; n++) begin
            s_rst_n = $urandom_range(0, 199) != 0;
            flag_init_end = $urandom_range(0, 3) != 0;
            ref_req = $urandom_range(0, 3) == 0;
            wr_req = $urandom_range(0, 1) == 1;
            rd_req = $urandom_range(0, 1) == 1;
            flag_ref_end = $urandom_range(0, 5) == 0;
            flag_wr_end = $urandom_range(0, 5) == 0;
            flag_rd_end = $urandom_range(0, 5) == 0;
            init_cmd = 4'($urandom); ref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
            init_addr = 12'($urandom); ref_addr = 12'($urandom); wr_addr = 12'($urandom); rd_addr = 12'($urandom);
            wr_bank = 2'($urandom); rd_bank = 2'($urandom); wr_data = 16'($urandom);
            step(1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
